// File: rtl/word_byte_unpacker.sv
// word_byte_unpacker: serializes valid/ready words into a bubble-free symbol stream with a per-block last flag
module word_byte_unpacker #(
  parameter int DATA_W      = 64,
  parameter int OUT_W       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int BLOCK_WORDS = 64
) (
  input  logic                           clk_50m,
  input  logic                           rst,
  input  logic                           i_word_valid,
  input  logic [DATA_W-1:0]              i_word,
  output logic                           o_word_ready,
  output logic                           o_byte_valid,
  output logic [OUT_W-1:0]               o_byte,
  output logic                           o_byte_last,
  input  logic                           i_byte_ready,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_cnt
);
  localparam int R = DATA_W / OUT_W;
  localparam int IW = R > 1 ? $clog2(R) : 1;
  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);
  logic [DATA_W-1:0] sh_reg, pf_reg;
  logic [R-1:0][OUT_W-1:0] lanes;
  logic sh_valid, pf_valid, take, fire, done;
  logic [IW-1:0] idx, sel;
  logic [CW-1:0] word_cnt;
  // ready comes from registers only, so the byte side never reaches the upstream handshake
  always_comb begin
    o_word_ready = !rst && !pf_valid;
    take = i_word_valid && o_word_ready;
    fire = sh_valid && i_byte_ready;
    done = fire && idx == LAST_IDX;
    lanes = sh_reg;
    sel = MSB_FIRST ? LAST_IDX - idx : idx;
    o_byte = lanes[sel];
    o_byte_valid = sh_valid;
    o_byte_last = sh_valid && idx == LAST_IDX && word_cnt == LAST_WORD;
    o_word_cnt = word_cnt;
  end
  // shift word refills from prefetch first, else straight from upstream, so words follow without bubbles
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sh_reg <= '0;
      pf_reg <= '0;
      sh_valid <= 1'b0;
      pf_valid <= 1'b0;
      idx <= '0;
      word_cnt <= '0;
    end else begin
      sh_valid <= done ? (pf_valid || take) : (sh_valid || take);
      sh_reg <= (done && pf_valid) ? pf_reg : (take && (done || !sh_valid)) ? i_word : sh_reg;
      pf_valid <= !done && (pf_valid || (take && sh_valid));
      pf_reg <= (take && sh_valid && !done) ? i_word : pf_reg;
      idx <= done ? '0 : fire ? idx + 1'b1 : idx;
      word_cnt <= done ? word_cnt + 1'b1 : word_cnt;
    end
  end
endmodule
